// File: rtl/dcache_flush_unit_if.sv
// -----------------------------------------------------------------------------
// dcache_flush_unit_if
//
// Bundle of signals between the dcache flush unit and its neighbours: the
// flush controller (flush request/acknowledge), the tag SRAM arbiter (set
// read, per-way valid/dirty return, invalidate write) and the miss unit
// (writeback request).
//
// Signals (direction as seen from the flush unit, i.e. the slave modport):
//   flush_i      in   flush request, level, held until acknowledge
//   flush_ack_o  out  one-cycle pulse when the whole cache has been flushed
//   busy_o       out  high while a walk is in progress (every state but IDLE)
//   tag_req_o    out  tag/status read request for set tag_idx_o
//   tag_gnt_i    in   tag read grant
//   tag_idx_o    out  set index used for the read and the invalidate
//   valid_i      in   per-way valid bits, returned one cycle after the grant
//   dirty_i      in   per-way dirty bits, same timing as valid_i
//   wb_valid_o   out  writeback request to the miss unit
//   wb_ready_i   in   writeback accepted
//   wb_way_o     out  way to write back
//   inv_req_o    out  clear valid+dirty of every way in set tag_idx_o
//   inv_gnt_i    in   invalidate write granted
//
// The master modport is the environment side (controller, arbiters, miss
// unit taken together).
// -----------------------------------------------------------------------------
interface dcache_flush_unit_if #(
    parameter int NR_SETS = 256,
    parameter int NR_WAYS = 8
);
    localparam int IDX_W = (NR_SETS > 1) ? $clog2(NR_SETS) : 1;
    localparam int WAY_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

    logic               flush_i;
    logic               flush_ack_o;
    logic               busy_o;
    logic               tag_req_o;
    logic               tag_gnt_i;
    logic [IDX_W-1:0]   tag_idx_o;
    logic [NR_WAYS-1:0] valid_i;
    logic [NR_WAYS-1:0] dirty_i;
    logic               wb_valid_o;
    logic               wb_ready_i;
    logic [WAY_W-1:0]   wb_way_o;
    logic               inv_req_o;
    logic               inv_gnt_i;

    modport slave (
        input  flush_i,
        output flush_ack_o,
        output busy_o,
        output tag_req_o,
        input  tag_gnt_i,
        output tag_idx_o,
        input  valid_i,
        input  dirty_i,
        output wb_valid_o,
        input  wb_ready_i,
        output wb_way_o,
        output inv_req_o,
        input  inv_gnt_i
    );

    modport master (
        output flush_i,
        input  flush_ack_o,
        input  busy_o,
        input  tag_req_o,
        output tag_gnt_i,
        input  tag_idx_o,
        output valid_i,
        output dirty_i,
        input  wb_valid_o,
        output wb_ready_i,
        input  wb_way_o,
        input  inv_req_o,
        output inv_gnt_i
    );
endinterface

// File: rtl/dcache_flush_unit.sv
// -----------------------------------------------------------------------------
// dcache_flush_unit
//
// Responder side of the data-cache flush handshake. On a flush request it
// walks every set of the write-back data cache: reads the set's valid/dirty
// bits, writes back each valid+dirty way (ascending way order) through the
// miss unit, then invalidates all ways of the set. After the last set it
// pulses flush_ack_o for one cycle.
//
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   fl      dcache_flush_unit_if.slave: controller, tag SRAM and miss-unit
//           handshakes (see the interface file for the signal list)
//
// Parameters:
//   NR_SETS  number of sets, power of two, >= 2
//   NR_WAYS  associativity, >= 1
// -----------------------------------------------------------------------------
module dcache_flush_unit #(
    parameter int NR_SETS = 256,
    parameter int NR_WAYS = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    dcache_flush_unit_if.slave      fl
);
    localparam int IDX_W = (NR_SETS > 1) ? $clog2(NR_SETS) : 1;
    localparam int WAY_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_SETS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_DATA,
        WRITEBACK,
        INVALIDATE,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NR_WAYS-1:0] pending_q, pending_d;

    logic               flush_ack;
    logic               busy;
    logic               tag_req;
    logic [IDX_W-1:0]   tag_idx;
    logic               wb_valid;
    logic [WAY_W-1:0]   wb_way;
    logic               inv_req;

    // Index of the lowest set bit; scanning downwards lets the lowest hit win.
    function automatic logic [WAY_W-1:0] lowest_way(input logic [NR_WAYS-1:0] m);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int i = NR_WAYS - 1; i >= 0; i--) begin
            if (m[i]) r = WAY_W'(i);
        end
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        flush_ack = 1'b0;
        busy      = (state_q != IDLE);
        tag_req   = 1'b0;
        tag_idx   = '0;
        wb_valid  = 1'b0;
        wb_way    = '0;
        inv_req   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fl.flush_i) begin
                    idx_d   = '0;
                    state_d = READ;
                end
            end

            READ: begin
                tag_req = 1'b1;
                tag_idx = idx_q;
                if (fl.tag_gnt_i) state_d = WAIT_DATA;
            end

            WAIT_DATA: begin
                // Tag SRAM returns the set's status bits in this cycle.
                tag_idx   = idx_q;
                pending_d = fl.valid_i & fl.dirty_i;
                state_d   = (|(fl.valid_i & fl.dirty_i)) ? WRITEBACK : INVALIDATE;
            end

            WRITEBACK: begin
                // wb_way follows pending_q, which only changes on acceptance,
                // so the way is stable while the miss unit back-pressures.
                wb_valid = 1'b1;
                tag_idx  = idx_q;
                wb_way   = lowest_way(pending_q);
                if (fl.wb_ready_i) begin
                    // m & (m-1) drops exactly the lowest set bit.
                    pending_d = pending_q & (pending_q - NR_WAYS'(1));
                    if ((pending_q & (pending_q - NR_WAYS'(1))) == '0) begin
                        state_d = INVALIDATE;
                    end
                end
            end

            INVALIDATE: begin
                inv_req = 1'b1;
                tag_idx = idx_q;
                if (fl.inv_gnt_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = READ;
                    end
                end
            end

            DONE: begin
                flush_ack = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fl.flush_ack_o = flush_ack;
    assign fl.busy_o      = busy;
    assign fl.tag_req_o   = tag_req;
    assign fl.tag_idx_o   = tag_idx;
    assign fl.wb_valid_o  = wb_valid;
    assign fl.wb_way_o    = wb_way;
    assign fl.inv_req_o   = inv_req;

endmodule

// File: tb/tb_dcache_flush_unit.sv
module tb_dcache_flush_unit;
    localparam int NS = 4;
    localparam int NW = 2;
    localparam int MAXC = 400;

    logic clk;
    logic rst_ni;

    dcache_flush_unit_if #(.NR_SETS(NS), .NR_WAYS(NW)) ifc ();

    dcache_flush_unit #(.NR_SETS(NS), .NR_WAYS(NW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .fl     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Tag SRAM contents per set
    logic [NW-1:0] tv [NS];
    logic [NW-1:0] td [NS];

    // Walk logs
    int rd_log[$];
    int inv_log[$];
    int wb_idx_log[$];
    int wb_way_log[$];
    int wb_acc_log[$];
    int inv_first[NS];
    int ack_count, ack_cycle, wbv_cycles;
    int mutex_err, busy_err, busy_after_err, stable_err;
    bit timed_out, aborted;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < NS; i++) begin
            tv[i] = '0;
            td[i] = '0;
        end
    endtask

    // Plays controller, tag SRAM and miss unit for one walk starting from IDLE.
    task automatic run_walk(input int stall_max, input int wb_hold, input int drop_at,
                            input int abort_set, input bit keep_flush);
        int c, tstall, istall, whold, rd_i;
        bit rd_pend, ptw, piw, pww;
        int pidx, pway;
        rd_log.delete(); inv_log.delete(); wb_idx_log.delete();
        wb_way_log.delete(); wb_acc_log.delete();
        for (int i = 0; i < NS; i++) inv_first[i] = -1;
        ack_count = 0; ack_cycle = -1; wbv_cycles = 0;
        mutex_err = 0; busy_err = 0; busy_after_err = 0; stable_err = 0;
        timed_out = 1'b0; aborted = 1'b0;
        tstall = 0; istall = 0; whold = 0; rd_i = 0;
        rd_pend = 0; ptw = 0; piw = 0; pww = 0; pidx = 0; pway = 0;
        ifc.flush_i = 1'b1;
        c = 0;
        while (c < MAXC) begin
            if ((int'(ifc.tag_req_o) + int'(ifc.wb_valid_o) + int'(ifc.inv_req_o)) > 1) mutex_err++;
            if (c >= 1 && ack_count == 0 && !ifc.busy_o) busy_err++;
            if (ack_count > 0 && !ifc.flush_ack_o && ifc.busy_o) busy_after_err++;
            if (ptw && !(ifc.tag_req_o && int'(ifc.tag_idx_o) == pidx)) stable_err++;
            if (piw && !(ifc.inv_req_o && int'(ifc.tag_idx_o) == pidx)) stable_err++;
            if (pww && !(ifc.wb_valid_o && int'(ifc.wb_way_o) == pway && int'(ifc.tag_idx_o) == pidx)) stable_err++;
            if (ifc.flush_ack_o) begin
                ack_count++;
                if (ack_cycle < 0) ack_cycle = c;
            end
            if (ifc.wb_valid_o) wbv_cycles++;
            if (abort_set >= 0 && ifc.wb_valid_o && int'(ifc.tag_idx_o) == abort_set) begin
                rst_ni = 1'b0;
                ifc.flush_i = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (drop_at >= 0 && c >= drop_at) ifc.flush_i = 1'b0;
            if (ifc.flush_ack_o && keep_flush) return;
            if (ifc.flush_ack_o) ifc.flush_i = 1'b0;
            // Status bits only meaningful the cycle after a grant; garbage otherwise
            if (rd_pend) begin
                ifc.valid_i = tv[rd_i];
                ifc.dirty_i = td[rd_i];
            end else begin
                ifc.valid_i = '1;
                ifc.dirty_i = '1;
            end
            if (stall_max == 0) begin
                ifc.tag_gnt_i = 1'b1;
                ifc.inv_gnt_i = 1'b1;
            end else begin
                if (ifc.tag_req_o) begin
                    if (!ptw) tstall = $urandom_range(0, stall_max);
                    ifc.tag_gnt_i = (tstall == 0);
                    if (tstall > 0) tstall--;
                end else ifc.tag_gnt_i = 1'b0;
                if (ifc.inv_req_o) begin
                    if (!piw) istall = $urandom_range(0, stall_max);
                    ifc.inv_gnt_i = (istall == 0);
                    if (istall > 0) istall--;
                end else ifc.inv_gnt_i = 1'b0;
            end
            if (ifc.wb_valid_o) begin
                if (!pww) whold = wb_hold;
                ifc.wb_ready_i = (whold == 0);
                if (whold > 0) whold--;
            end else ifc.wb_ready_i = (wb_hold == 0);
            // Log what the next edge will commit
            rd_pend = ifc.tag_req_o && ifc.tag_gnt_i;
            if (rd_pend) begin
                rd_i = int'(ifc.tag_idx_o);
                rd_log.push_back(rd_i);
            end
            if (ifc.wb_valid_o && ifc.wb_ready_i) begin
                wb_idx_log.push_back(int'(ifc.tag_idx_o));
                wb_way_log.push_back(int'(ifc.wb_way_o));
                wb_acc_log.push_back(c);
            end
            if (ifc.inv_req_o && !piw) inv_first[ifc.tag_idx_o] = c;
            if (ifc.inv_req_o && ifc.inv_gnt_i) inv_log.push_back(int'(ifc.tag_idx_o));
            ptw = ifc.tag_req_o && !ifc.tag_gnt_i;
            piw = ifc.inv_req_o && !ifc.inv_gnt_i;
            pww = ifc.wb_valid_o && !ifc.wb_ready_i;
            pidx = int'(ifc.tag_idx_o);
            pway = int'(ifc.wb_way_o);
            if (ack_count > 0 && c >= ack_cycle + 4) return;
            step();
            c++;
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        ifc.flush_i = 1'b1;
        ifc.tag_gnt_i = 1'b1; ifc.inv_gnt_i = 1'b1; ifc.wb_ready_i = 1'b1;
        ifc.valid_i = '1; ifc.dirty_i = '1;
        step(); step();
        checks++;
        if ({ifc.flush_ack_o, ifc.busy_o, ifc.tag_req_o, ifc.wb_valid_o, ifc.inv_req_o,
             ifc.tag_idx_o, ifc.wb_way_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b busy=%b tag_req=%b wb_valid=%b inv_req=%b idx=%0d way=%0d, required all 0",
                     ifc.flush_ack_o, ifc.busy_o, ifc.tag_req_o, ifc.wb_valid_o, ifc.inv_req_o,
                     ifc.tag_idx_o, ifc.wb_way_o);
        end
        ifc.flush_i = 1'b0;
        rst_ni = 1'b1;
        step();
        checks++;
        if (ifc.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_no_flush: busy=%b required 0", ifc.busy_o);
        end
    endtask

    task automatic test_clean();
        bit ok;
        clear_tbl();
        run_walk(0, 0, -1, -1, 1'b0);
        ok = (rd_log.size() == 4);
        for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != i) ok = 0;
        checks++;
        if (!ok) begin failures++; $display("FAIL clean_read_order: got %p required 0,1,2,3", rd_log); end
        checks++;
        if (wb_idx_log.size() != 0 || wbv_cycles != 0) begin
            failures++; $display("FAIL clean_no_wb: writebacks=%0d wb_valid cycles=%0d required 0", wb_idx_log.size(), wbv_cycles);
        end
        ok = (inv_log.size() == 4);
        for (int i = 0; i < inv_log.size(); i++) if (inv_log[i] != i) ok = 0;
        checks++;
        if (!ok) begin failures++; $display("FAIL clean_inv_order: got %p required 0,1,2,3", inv_log); end
        checks++;
        if (ack_count != 1 || ack_cycle != 13) begin
            failures++; $display("FAIL clean_ack: count=%0d cycle=%0d required 1 at 13", ack_count, ack_cycle);
        end
        checks++;
        if (busy_err != 0 || busy_after_err != 0) begin
            failures++; $display("FAIL clean_busy: low-during-walk=%0d high-after=%0d required 0,0", busy_err, busy_after_err);
        end
        checks++;
        if (mutex_err != 0 || timed_out) begin
            failures++; $display("FAIL clean_mutex: overlaps=%0d timeout=%0d required 0,0", mutex_err, timed_out);
        end
    endtask

    task automatic test_writeback_two_ways();
        clear_tbl();
        tv[2] = 2'b11; td[2] = 2'b11;
        run_walk(0, 0, -1, -1, 1'b0);
        checks++;
        if (wb_idx_log.size() != 2) begin
            failures++; $display("FAIL wb2_count: got %0d required 2", wb_idx_log.size());
        end else begin
            checks++;
            if (wb_idx_log[0] != 2 || wb_way_log[0] != 0 || wb_idx_log[1] != 2 || wb_way_log[1] != 1) begin
                failures++;
                $display("FAIL wb2_order: got (%0d,%0d),(%0d,%0d) required (2,0),(2,1)",
                         wb_idx_log[0], wb_way_log[0], wb_idx_log[1], wb_way_log[1]);
            end
            checks++;
            if (!(wb_acc_log[1] < inv_first[2])) begin
                failures++; $display("FAIL wb2_before_inv: last wb cycle=%0d inv cycle=%0d required wb earlier", wb_acc_log[1], inv_first[2]);
            end
        end
        checks++;
        if (ack_count != 1 || ack_cycle != 15 || mutex_err != 0) begin
            failures++; $display("FAIL wb2_ack: count=%0d cycle=%0d overlaps=%0d required 1 at 15, 0", ack_count, ack_cycle, mutex_err);
        end
    endtask

    task automatic test_wb_backpressure();
        clear_tbl();
        tv[1] = 2'b10; td[1] = 2'b10;
        run_walk(0, 5, -1, -1, 1'b0);
        checks++;
        if (wb_idx_log.size() != 1 || wbv_cycles != 6 || stable_err != 0) begin
            failures++; $display("FAIL bp_hold: wbs=%0d wb_valid cycles=%0d unstable=%0d required 1,6,0", wb_idx_log.size(), wbv_cycles, stable_err);
        end else begin
            checks++;
            if (wb_idx_log[0] != 1 || wb_way_log[0] != 1 || inv_first[1] != wb_acc_log[0] + 1) begin
                failures++;
                $display("FAIL bp_order: wb=(%0d,%0d) at %0d inv at %0d required (1,1) then inv next cycle",
                         wb_idx_log[0], wb_way_log[0], wb_acc_log[0], inv_first[1]);
            end
        end
        checks++;
        if (ack_count != 1 || ack_cycle != 19) begin
            failures++; $display("FAIL bp_ack: count=%0d cycle=%0d required 1 at 19", ack_count, ack_cycle);
        end
    endtask

    task automatic test_clean_and_invalid_lines();
        clear_tbl();
        tv[0] = 2'b01; td[0] = 2'b00;
        tv[1] = 2'b10; td[1] = 2'b01;
        tv[3] = 2'b00; td[3] = 2'b10;
        run_walk(0, 0, -1, -1, 1'b0);
        checks++;
        if (wb_idx_log.size() != 0) begin
            failures++; $display("FAIL nodirty_no_wb: got %0d writebacks required 0", wb_idx_log.size());
        end
        checks++;
        if (inv_log.size() != 4 || ack_count != 1 || ack_cycle != 13) begin
            failures++; $display("FAIL nodirty_inv: invs=%0d acks=%0d ack cycle=%0d required 4,1,13", inv_log.size(), ack_count, ack_cycle);
        end
    endtask

    task automatic test_grant_stalls();
        bit ok;
        clear_tbl();
        tv[3] = 2'b01; td[3] = 2'b01;
        run_walk(3, 1, -1, -1, 1'b0);
        checks++;
        if (stable_err != 0 || mutex_err != 0) begin
            failures++; $display("FAIL stall_stable: unstable=%0d overlaps=%0d required 0,0", stable_err, mutex_err);
        end
        ok = (rd_log.size() == 4) && (inv_log.size() == 4);
        for (int i = 0; i < 4 && ok; i++) if (rd_log[i] != i || inv_log[i] != i) ok = 0;
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_order: reads %p invs %p required 0..3", rd_log, inv_log); end
        checks++;
        if (ack_count != 1 || timed_out || wb_idx_log.size() != 1) begin
            failures++; $display("FAIL stall_ack: acks=%0d timeout=%0d wbs=%0d required 1,0,1", ack_count, timed_out, wb_idx_log.size());
        end
    endtask

    task automatic test_flush_drop();
        clear_tbl();
        run_walk(0, 0, 4, -1, 1'b0);
        checks++;
        if (ack_count != 1 || ack_cycle != 13) begin
            failures++; $display("FAIL drop_ack: count=%0d cycle=%0d required 1 at 13", ack_count, ack_cycle);
        end
    endtask

    task automatic test_back_to_back();
        clear_tbl();
        run_walk(0, 0, -1, -1, 1'b1);
        checks++;
        if (ack_cycle != 13) begin
            failures++; $display("FAIL b2b_first_ack: cycle=%0d required 13", ack_cycle);
        end
        step();
        checks++;
        if (ifc.busy_o !== 1'b0 || ifc.flush_ack_o !== 1'b0) begin
            failures++; $display("FAIL b2b_idle: busy=%b ack=%b required 0,0", ifc.busy_o, ifc.flush_ack_o);
        end
        step();
        checks++;
        if (ifc.tag_req_o !== 1'b1 || ifc.tag_idx_o !== 2'd0 || ifc.busy_o !== 1'b1) begin
            failures++; $display("FAIL b2b_restart: tag_req=%b idx=%0d busy=%b required 1,0,1", ifc.tag_req_o, ifc.tag_idx_o, ifc.busy_o);
        end
        ifc.flush_i = 1'b0;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_wb();
        clear_tbl();
        tv[1] = 2'b11; td[1] = 2'b11;
        run_walk(0, 2, -1, 1, 1'b0);
        checks++;
        if (!aborted) begin
            failures++; $display("FAIL abort_reached: reached WRITEBACK at set 1=%0d required 1", aborted);
        end
        step();
        checks++;
        if ({ifc.flush_ack_o, ifc.busy_o, ifc.tag_req_o, ifc.wb_valid_o, ifc.inv_req_o,
             ifc.tag_idx_o, ifc.wb_way_o} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: ack=%b busy=%b tag_req=%b wb_valid=%b inv_req=%b idx=%0d way=%0d, required all 0",
                     ifc.flush_ack_o, ifc.busy_o, ifc.tag_req_o, ifc.wb_valid_o, ifc.inv_req_o,
                     ifc.tag_idx_o, ifc.wb_way_o);
        end
        rst_ni = 1'b1;
        clear_tbl();
        run_walk(0, 0, -1, -1, 1'b0);
        checks++;
        if (rd_log.size() < 1 || rd_log[0] != 0 || ack_count != 1 || ack_cycle != 13) begin
            failures++; $display("FAIL abort_restart: reads %p acks=%0d cycle=%0d required first 0, 1 ack at 13", rd_log, ack_count, ack_cycle);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_clean();
        test_writeback_two_ways();
        test_wb_backpressure();
        test_clean_and_invalid_lines();
        test_grant_stalls();
        test_flush_drop();
        test_back_to_back();
        test_reset_mid_wb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_flush_unit.md
Name: dcache_flush_unit

Overview:
- Responder side of the data-cache flush handshake. It receives the registered dcache flush request from the flush controller and walks every set of the write-back data cache.
- For each set it writes back every valid+dirty way through the miss/writeback port, then invalidates all ways of the set.
- When the walk completes it pulses the flush acknowledge back to the controller. It sits inside the write-back dcache, between the flush controller and the tag SRAM / miss-unit arbiters.

Parameters:
- NR_SETS, 256, number of cache sets; power of two, >= 2
- NR_WAYS, 8, associativity; >= 1
- IDX_W, max(1,$clog2(NR_SETS)), set index width (derived, not overridden)

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, synchronous, active-low
- flush_i  input  1  flush request from controller; level, held until ack
- flush_ack_o  output  1  single-cycle pulse: whole cache flushed
- busy_o  output  1  high in every state except IDLE
- tag_req_o  output  1  tag/status read request
- tag_gnt_i  input  1  tag read grant
- tag_idx_o  output  IDX_W  set index for read and invalidate
- valid_i  input  NR_WAYS  per-way valid bits; valid exactly one cycle after the grant cycle
- dirty_i  input  NR_WAYS  per-way dirty bits; same timing as valid_i
- wb_valid_o  output  1  writeback request to miss unit
- wb_ready_i  input  1  writeback accepted
- wb_way_o  output  $clog2(NR_WAYS) (min 1)  way to write back
- inv_req_o  output  1  clear valid+dirty of all ways at tag_idx_o
- inv_gnt_i  input  1  invalidate write granted

Behaviour:
- Reset is synchronous, active-low; it is sampled only on clk_i rising edge.
- Reset values: state=IDLE, idx=0, pending=0. All outputs are 0: flush_ack_o, busy_o, tag_req_o, wb_valid_o, inv_req_o, tag_idx_o, wb_way_o.
- Reset asserted mid-walk aborts the walk: next cycle is IDLE, no ack is issued, and no request stays asserted.
- States: IDLE, READ, WAIT_DATA, WRITEBACK, INVALIDATE, DONE.
- IDLE: if flush_i=1, load idx=0 and go to READ. Otherwise stay in IDLE.
- READ: drive tag_req_o=1, tag_idx_o=idx. Hold both until tag_gnt_i=1, then go to WAIT_DATA.
- WAIT_DATA:
  - Capture pending = valid_i & dirty_i.
  - If pending is nonzero, go to WRITEBACK; else go to INVALIDATE.
  - No request is asserted in this state.
- WRITEBACK:
  - Drive wb_valid_o=1 and wb_way_o = index of the lowest set bit of pending. wb_way_o is stable while wb_valid_o=1 and wb_ready_i=0.
  - Handshake completes when wb_valid_o & wb_ready_i. On completion, clear that bit of pending.
  - If the cleared mask is zero, go to INVALIDATE; else stay in WRITEBACK.
  - Exactly one writeback is issued per dirty valid way, in ascending way order.
  - wb_valid_o may stay high across back-to-back accepted writebacks.
- INVALIDATE: drive inv_req_o=1, tag_idx_o=idx. On inv_gnt_i:
  - if idx == NR_SETS-1, go to DONE;
  - else idx = idx+1 and go to READ.
- DONE: flush_ack_o=1 for exactly one cycle, then go to IDLE.
- tag_idx_o holds idx in READ, WAIT_DATA, WRITEBACK and INVALIDATE. It reads 0 in IDLE.
- Requests are mutually exclusive: at most one of tag_req_o, wb_valid_o, inv_req_o is high in any cycle.
- flush_i falling mid-walk is ignored; the walk completes and acks.
- flush_i high in IDLE the cycle after DONE starts a new full walk. Back-to-back fence.t flushes are legal.
- Index counter: idx is IDX_W bits and increments only in INVALIDATE on grant. Wrap from NR_SETS-1 never occurs; DONE is taken instead.
- Minimum latency, with all grants and ready tied high and no dirty lines: 3*NR_SETS + 1 cycles from the first cycle flush_i is sampled high in IDLE to the flush_ack_o pulse.
  - 1 cycle IDLE -> READ, then 3 cycles per set (READ, WAIT_DATA, INVALIDATE).
  - The ack pulse occurs in the DONE cycle.
  - Each writeback adds at least 1 cycle.

Test Plan (NR_SETS=4, NR_WAYS=2):
- Clean cache: grants and ready held at 1, valid=dirty=0, flush_i=1. Required response:
  - tag_idx_o steps 0,1,2,3;
  - no wb_valid_o;
  - 4 invalidates;
  - flush_ack_o pulses exactly once, 13 cycles after the start cycle;
  - busy_o is high from the cycle after the start until the ack cycle inclusive.
- Set 2, ways 0 and 1 valid+dirty, wb_ready_i=1: exactly two writebacks, at idx=2 with way 0 then way 1. Both occur before the inv_req_o for idx 2.
- Set 1, way 1 valid+dirty with wb_ready_i held low 5 cycles: wb_valid_o stays high and wb_way_o stays 1 for 5 cycles. The writeback completes on the 6th cycle, then INVALIDATE.
- Valid but clean line (valid=1, dirty=0) and dirty but invalid line (valid=0, dirty=1): neither produces a writeback, and invalidate is still issued.
- tag_gnt_i and inv_gnt_i randomly stalled 0-3 cycles: tag_req_o/inv_req_o and tag_idx_o stay stable until grant. Final ack occurs once, and the set order is 0..3.
- Reset pulled low during WRITEBACK at set 1: the next cycle has all outputs 0 and state IDLE. A subsequent flush_i restarts at idx 0 and acks normally.
